// File: rtl/reloj_hhmm_pkg.sv
`default_nettype none
// reloj_hhmm_pkg: shared state encoding, field limits and decimal-point patterns.
package reloj_hhmm_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    SET_H = 2'd1,
    SET_M = 2'd2
  } state_e;

  localparam logic [4:0] MAX_H = 5'd23;
  localparam logic [5:0] MAX_M = 6'd59;
  localparam logic [5:0] MAX_S = 6'd59;

  localparam logic [3:0] PTS_OFF   = 4'b1111;
  localparam logic [3:0] PTS_COLON = 4'b1011;
  localparam logic [3:0] PTS_SET_H = 4'b0011;
  localparam logic [3:0] PTS_SET_M = 4'b1100;

  function automatic logic [5:0] inc_wrap6(input logic [5:0] v, input logic [5:0] max);
    return (v == max) ? 6'd0 : v + 6'd1;
  endfunction

  function automatic logic [4:0] inc_wrap5(input logic [4:0] v, input logic [4:0] max);
    return (v == max) ? 5'd0 : v + 5'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/reloj_hhmm_btn_edge.sv
`default_nettype none
// btn_edge: two-flop synchronizer followed by a registered rising-edge pulse
// (pulse is high for one cycle, three clk edges after the raw rise).
module btn_edge (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic pulse
);

  logic sync1_q, sync2_q, prev_q, pulse_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      pulse_q <= sync2_q & ~prev_q;
    end
  end

  assign pulse = pulse_q;

endmodule
`default_nettype wire

// File: rtl/reloj_hhmm.sv
`default_nettype none
// reloj_hhmm: 24-hour HH:MM:SS timekeeper with two-button set mode, feeding
// the 7-segment display driver with binary hours/minutes and decimal points.
module reloj_hhmm
  import reloj_hhmm_pkg::*;
#(
  parameter int TICKS_PER_SEC = 50000000,
  parameter int PRESC_W       = 26
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       btn_mode,
  input  logic       btn_up,
  output logic [7:0] datahours,
  output logic [7:0] dataminutes,
  output logic [3:0] datapoints,
  output logic       sec_tick
);

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICKS_PER_SEC - 1);
  localparam logic [PRESC_W-1:0] PRESC_HALF = PRESC_W'(TICKS_PER_SEC / 2);

  logic mode_p, up_p;

  btn_edge u_btn_mode (.clk(clk), .reset(reset), .din(btn_mode), .pulse(mode_p));
  btn_edge u_btn_up   (.clk(clk), .reset(reset), .din(btn_up),   .pulse(up_p));

  state_e               state_q;
  logic [PRESC_W-1:0]   presc_q;
  logic [4:0]           hours_q;
  logic [5:0]           minutes_q;
  logic [5:0]           seconds_q;
  logic [3:0]           points_q;
  logic                 tick_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= RUN;
      presc_q   <= '0;
      hours_q   <= '0;
      minutes_q <= '0;
      seconds_q <= '0;
      points_q  <= PTS_OFF;
      tick_q    <= 1'b0;
    end else begin
      tick_q <= 1'b0;

      // Points follow the state/prescaler seen this cycle, so they lag by one.
      case (state_q)
        RUN:     points_q <= (presc_q < PRESC_HALF) ? PTS_COLON : PTS_OFF;
        SET_H:   points_q <= PTS_SET_H;
        SET_M:   points_q <= PTS_SET_M;
        default: points_q <= PTS_OFF;
      endcase

      case (state_q)
        RUN: begin
          if (enable) begin
            if (presc_q == PRESC_LAST) begin
              presc_q <= '0;
              tick_q  <= 1'b1;
              seconds_q <= inc_wrap6(seconds_q, MAX_S);
              if (seconds_q == MAX_S) begin
                minutes_q <= inc_wrap6(minutes_q, MAX_M);
                if (minutes_q == MAX_M) begin
                  hours_q <= inc_wrap5(hours_q, MAX_H);
                end
              end
            end else begin
              presc_q <= presc_q + 1'b1;
            end
          end
          if (mode_p) begin
            state_q <= SET_H;
          end
        end
        SET_H: begin
          if (mode_p) begin
            state_q <= SET_M;
          end else if (up_p) begin
            hours_q <= inc_wrap5(hours_q, MAX_H);
          end
        end
        SET_M: begin
          if (mode_p) begin
            state_q   <= RUN;
            seconds_q <= '0;
            presc_q   <= '0;
          end else if (up_p) begin
            minutes_q <= inc_wrap6(minutes_q, MAX_M);
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

  assign datahours   = {3'b000, hours_q};
  assign dataminutes = {2'b00, minutes_q};
  assign datapoints  = points_q;
  assign sec_tick    = tick_q;

endmodule
`default_nettype wire

// File: doc/reloj_hhmm.md
Name: reloj_hhmm

Overview:
Timekeeping stage directly upstream of the four-digit 7-segment display driver. Keeps a 24-hour clock (hours, minutes, seconds) and drives the display driver's datahours, dataminutes and datapoints inputs. Provides a two-button set mode: a mode button selects the field, an up button increments it. The display driver's binary-to-BCD converters consume the binary hour/minute outputs directly.

Parameters:
TICKS_PER_SEC, 50000000, clk cycles per second; use 10 in simulation.
PRESC_W, 26, prescaler width; must satisfy 2^PRESC_W > TICKS_PER_SEC.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high; all state cleared on the clk edge where reset=1
enable  in  1  1 = time advances in RUN; 0 = prescaler and time frozen
btn_mode  in  1  raw async level, debounced externally; rising edge cycles mode
btn_up  in  1  raw async level, debounced externally; rising edge increments selected field
datahours  out  8  binary hours 0..23 (upper bits 0)
dataminutes  out  8  binary minutes 0..59
datapoints  out  4  decimal points, active-low; bit3 = leftmost digit
sec_tick  out  1  one-cycle pulse at each seconds increment

Behaviour:
- Reset values: datahours=0, dataminutes=0, seconds=0, prescaler=0, state=RUN, datapoints=4'b1111, sec_tick=0.
- Buttons: 2-FF synchronizer, then rising-edge detect. One-cycle pulse appears 3 clk edges after the raw rise. Held buttons produce no repeat.
- Prescaler, RUN with enable=1: counts 0..TICKS_PER_SEC-1 and wraps to 0. At the wrap, sec_tick=1 for that cycle and seconds increment.
- Seconds 59 -> 0 increments minutes; minutes 59 -> 0 increments hours; hours 23 -> 0. Full rollover: 23:59:59 -> 00:00:00 in one tick.
- enable=0 in RUN: prescaler, seconds, minutes and hours all hold.
- State machine (3 states):
  - RUN --mode pulse--> SET_H --mode pulse--> SET_M --mode pulse--> RUN.
  - On SET_M -> RUN: seconds and prescaler are cleared to 0.
  - In SET_H/SET_M: prescaler frozen, sec_tick=0. Each up pulse increments the selected field only (hours wraps 23->0, minutes wraps 59->0) with no carry. Seconds are untouched.
  - In RUN: up pulses are ignored.
- datapoints:
  - RUN: 4'b1011 (colon on, bit2 low) while prescaler < TICKS_PER_SEC/2, else 4'b1111. Gives a 1 Hz blink.
  - SET_H: 4'b0011. SET_M: 4'b1100.
  - Registered; updates one cycle after a state or prescaler change.
- Simultaneous events:
  - Tick and mode pulse on the same edge in RUN: the tick is applied and the state moves to SET_H.
  - Mode and up pulses on the same edge: the mode pulse wins and the up pulse is dropped.
- Reset mid-set returns to RUN at 00:00:00. Reset dominates all other inputs.
- All outputs are registered. No combinational path from any input to any output.

Decomposition:
- Shared package holds:
  - state encoding: RUN=2'd0, SET_H=2'd1, SET_M=2'd2;
  - constants MAX_H=23, MAX_M=59, MAX_S=59;
  - point patterns PTS_OFF=4'b1111, PTS_COLON=4'b1011, PTS_SET_H=4'b0011, PTS_SET_M=4'b1100.
- One sub-module, btn_edge: 2-FF synchronizer plus rising-edge pulse, with ports clk, reset, din, pulse. Instantiated for btn_mode and btn_up.

Test Plan (TICKS_PER_SEC=10):
- Reset run: assert reset 2 cycles, release with enable=1, run 600 cycles -> dataminutes=1, datahours=0, 60 sec_tick pulses spaced 10 cycles apart.
- Blink: in RUN, sample datapoints -> 4'b1011 for 5 cycles, then 4'b1111 for 5 cycles, repeating.
- Full rollover: set 23:59, return to RUN, run 600 cycles -> 00:00 on the cycle after the 60th sec_tick.
- Set mode:
  - one mode press -> datapoints=4'b0011;
  - 25 up presses -> datahours=1 (wrapped once);
  - mode press, 61 up presses -> dataminutes=1;
  - mode press -> RUN, seconds=0, first sec_tick exactly 10 cycles later.
- Enable freeze: enable=0 for 100 cycles in RUN -> no sec_tick, time unchanged; re-enable resumes from the held prescaler value.
- Corner cases:
  - up press in RUN -> no change;
  - mode and up rising on the same cycle from RUN -> SET_H, hours unchanged;
  - reset asserted during SET_M -> RUN, 00:00, datapoints=4'b1111.
